// File: rtl/masked_feeder_pkg.sv
// Shared types and constants for the masked share feeder.
// Holds the FSM state type, the PRNG constants and a saturating counter helper.
package masked_feeder_pkg;

  typedef enum logic {
    WAIT_SEED = 1'b0,
    RUN       = 1'b1
  } feeder_state_e;

  localparam int          LFSR_W_DEF    = 32;
  // Fibonacci taps 32,22,2,1 as a bit mask over the state word.
  localparam logic [31:0] LFSR_TAP_MASK = 32'h8020_0003;
  localparam logic [31:0] ZERO_SEED_SUB = 32'h0000_0001;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/share_lfsr.sv
// Fibonacci LFSR that supplies masks and gadget randomness.
// It loads on a seed strobe (never zero) and steps only when told to.
module share_lfsr
  import masked_feeder_pkg::*;
#(
  parameter int LFSR_W = LFSR_W_DEF,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [OUT_W-1:0]  word
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAP_MASK);
  localparam logic [LFSR_W-1:0] ONE  = LFSR_W'(ZERO_SEED_SUB);

  logic [LFSR_W-1:0] state;
  logic              feedback;

  assign feedback = ^(state & TAPS);
  assign word     = state[OUT_W-1:0];

  // NOTE: sequential state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ONE;
    end else if (load) begin
      // An all-zero state would lock the LFSR, so a zero seed is replaced.
      state <= (seed == '0) ? ONE : seed;
    end else if (step) begin
      state <= {state[LFSR_W-2:0], feedback};
    end
  end

endmodule

// File: rtl/masked_share_feeder.sv
// Splits unmasked operand pairs into Boolean shares for a two-stage masked AND gadget.
// Keeps the rand words stable across the gadget window and enforces periodic reseeding.
module masked_share_feeder
  import masked_feeder_pkg::*;
#(
  parameter int WIDTH           = 4,   // 4*WIDTH must not exceed LFSR_W
  parameter int LFSR_W          = LFSR_W_DEF,
  parameter int RESEED_INTERVAL = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] seed,
  input  logic              seed_valid,
  output logic              reseed_req,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  a_share0,
  output logic [WIDTH-1:0]  a_share1,
  output logic [WIDTH-1:0]  b_share0,
  output logic [WIDTH-1:0]  b_share1,
  output logic [WIDTH-1:0]  rand0,
  output logic [WIDTH-1:0]  rand1,
  output logic              share_valid,
  output logic              res_valid,
  output logic [15:0]       reseed_count
);

  localparam int          RAND_W   = 4 * WIDTH;
  localparam logic [15:0] INTERVAL = 16'(RESEED_INTERVAL);

  feeder_state_e      state;
  logic               hold;
  logic [15:0]        txn_cnt;
  logic               valid_mid;
  logic               accept;
  logic               seed_load;
  logic [RAND_W-1:0]  rnd;
  logic [WIDTH-1:0]   mask_a;
  logic [WIDTH-1:0]   mask_b;

  assign reseed_req = (state == WAIT_SEED);
  assign in_ready   = (state == RUN) && !hold;
  assign accept     = in_valid && in_ready;
  assign seed_load  = (state == WAIT_SEED) && seed_valid;

  assign mask_a = rnd[WIDTH-1:0];
  assign mask_b = rnd[2*WIDTH-1:WIDTH];

  share_lfsr #(
    .LFSR_W (LFSR_W),
    .OUT_W  (RAND_W)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (seed_load),
    .seed (seed),
    .step (accept),
    .word (rnd)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= WAIT_SEED;
      hold         <= 1'b0;
      txn_cnt      <= '0;
      reseed_count <= '0;
      a_share0     <= '0;
      a_share1     <= '0;
      b_share0     <= '0;
      b_share1     <= '0;
      rand0        <= '0;
      rand1        <= '0;
      share_valid  <= 1'b0;
      valid_mid    <= 1'b0;
      res_valid    <= 1'b0;
    end else begin
      // res_valid trails share_valid by the gadget's two register stages.
      share_valid <= accept;
      valid_mid   <= share_valid;
      res_valid   <= valid_mid;
      hold        <= accept;

      case (state)
        WAIT_SEED: begin
          if (seed_valid) begin
            reseed_count <= sat_inc16(reseed_count);
            txn_cnt      <= '0;
            state        <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            // Shares and rand words only move here, so they stay put through the gadget window.
            a_share0 <= in_a ^ mask_a;
            a_share1 <= mask_a;
            b_share0 <= in_b ^ mask_b;
            b_share1 <= mask_b;
            rand0    <= rnd[3*WIDTH-1:2*WIDTH];
            rand1    <= rnd[4*WIDTH-1:3*WIDTH];
            txn_cnt  <= txn_cnt + 16'd1;
            if (txn_cnt + 16'd1 == INTERVAL) begin
              state <= WAIT_SEED;
            end
          end
        end
        default: state <= WAIT_SEED;
      endcase
    end
  end

endmodule

// File: tb/tb_masked_share_feeder.sv
// Directed bench for masked_share_feeder: table-driven share vectors plus reseed and reset sequences.
// A behavioural two-stage masked AND recombines the shares to confirm rand stability.
module tb_masked_share_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] seed = '0;
  logic        seed_valid = 1'b0;
  logic        in_valid = 1'b0;
  logic        seed_valid3 = 1'b0;
  logic        in_valid3 = 1'b0;
  logic [3:0]  in_a = '0;
  logic [3:0]  in_b = '0;

  logic        reseed_req, in_ready, share_valid, res_valid;
  logic [3:0]  a_share0, a_share1, b_share0, b_share1, rand0, rand1;
  logic [15:0] reseed_count;

  logic        reseed_req3, in_ready3, share_valid3, res_valid3;
  logic [3:0]  a_share0_3, a_share1_3, b_share0_3, b_share1_3, rand0_3, rand1_3;
  logic [15:0] reseed_count3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  masked_share_feeder #(.WIDTH(4), .LFSR_W(32), .RESEED_INTERVAL(256)) dut (
    .clk(clk), .rst(rst), .seed(seed), .seed_valid(seed_valid), .reseed_req(reseed_req),
    .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
    .a_share0(a_share0), .a_share1(a_share1), .b_share0(b_share0), .b_share1(b_share1),
    .rand0(rand0), .rand1(rand1), .share_valid(share_valid), .res_valid(res_valid),
    .reseed_count(reseed_count)
  );

  masked_share_feeder #(.WIDTH(4), .LFSR_W(32), .RESEED_INTERVAL(3)) dut3 (
    .clk(clk), .rst(rst), .seed(seed), .seed_valid(seed_valid3), .reseed_req(reseed_req3),
    .in_a(in_a), .in_b(in_b), .in_valid(in_valid3), .in_ready(in_ready3),
    .a_share0(a_share0_3), .a_share1(a_share1_3), .b_share0(b_share0_3), .b_share1(b_share1_3),
    .rand0(rand0_3), .rand1(rand1_3), .share_valid(share_valid3), .res_valid(res_valid3),
    .reseed_count(reseed_count3)
  );

  // Behavioural gadget: cross terms masked at E1, r0^r1 cancels at E2.
  logic [3:0] g_s0, g_s1, g_out0, g_out1;
  always @(posedge clk) begin
    g_s0   <= (a_share0 & b_share1) ^ rand0;
    g_s1   <= (a_share1 & b_share0) ^ rand1;
    g_out0 <= (a_share0 & b_share0) ^ g_s0 ^ rand1;
    g_out1 <= (a_share1 & b_share1) ^ g_s1 ^ rand0;
  end

  typedef struct {
    logic [3:0] a, b, a0, a1, b0, b1, r0, r1, prod;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_shares(input string name, input int k);
    check(name, 32'({a_share0, a_share1, b_share0, b_share1, rand0, rand1}),
          32'({tbl[k].a0, tbl[k].a1, tbl[k].b0, tbl[k].b1, tbl[k].r0, tbl[k].r1}));
  endtask

  logic       acc;
  logic [2:0] hist;
  int         n_acc;
  int         last;
  int         k;
  int         q[$];

  initial begin
    // LFSR words from seed 32'hACE1: 0000ACE1, 000159C3, 0002B386, 0005670D, 000ACE1B, 00159C36.
    tbl[0] = '{a:4'hB, b:4'h6, a0:4'hA, a1:4'h1, b0:4'h8, b1:4'hE, r0:4'hC, r1:4'hA, prod:4'h2};
    tbl[1] = '{a:4'hF, b:4'hF, a0:4'hC, a1:4'h3, b0:4'h3, b1:4'hC, r0:4'h9, r1:4'h5, prod:4'hF};
    tbl[2] = '{a:4'h0, b:4'hF, a0:4'h6, a1:4'h6, b0:4'h7, b1:4'h8, r0:4'h3, r1:4'hB, prod:4'h0};
    tbl[3] = '{a:4'hA, b:4'h5, a0:4'h7, a1:4'hD, b0:4'h5, b1:4'h0, r0:4'h7, r1:4'h6, prod:4'h0};
    tbl[4] = '{a:4'hC, b:4'hA, a0:4'h7, a1:4'hB, b0:4'hB, b1:4'h1, r0:4'hE, r1:4'hC, prod:4'h8};
    tbl[5] = '{a:4'h7, b:4'h9, a0:4'h1, a1:4'h6, b0:4'hA, b1:4'h3, r0:4'hC, r1:4'h9, prod:4'h1};

    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    check("rst_reseed_req", 32'(reseed_req), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_valids", 32'({share_valid, res_valid}), 32'd0);
    check("rst_reseed_count", 32'(reseed_count), 32'd0);
    check("rst_shares", 32'({a_share0, a_share1, b_share0, b_share1, rand0, rand1}), 32'd0);

    // Seed load
    rst = 1'b1;
    seed = 32'h0000_ACE1;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    check("seed_reseed_req", 32'(reseed_req), 32'd0);
    check("seed_reseed_count", 32'(reseed_count), 32'd1);
    check("seed_in_ready", 32'(in_ready), 32'd1);

    // Single transaction B,6
    in_a = tbl[0].a;
    in_b = tbl[0].b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("c1_share_valid", 32'(share_valid), 32'd1);
    check("c1_a_recombine", 32'(a_share0 ^ a_share1), 32'hB);
    check("c1_b_recombine", 32'(b_share0 ^ b_share1), 32'h6);
    check_shares("c1_shares", 0);
    check("c1_hold", 32'(in_ready), 32'd0);
    tick();
    check("c2_valids", 32'({share_valid, res_valid}), 32'd0);
    check_shares("c2_shares_held", 0);
    tick();
    check("c3_res_valid", 32'(res_valid), 32'd1);
    check("c3_gadget", 32'(g_out0 ^ g_out1), 32'h2);
    tick();
    check("c4_res_valid", 32'(res_valid), 32'd0);

    // Streaming: in_valid high for 10 cycles, then drain
    hist  = '0;
    n_acc = 0;
    last  = 0;
    for (int i = 0; i < 14; i++) begin
      in_valid = (i < 10);
      if (n_acc < 5) begin
        in_a = tbl[1 + n_acc].a;
        in_b = tbl[1 + n_acc].b;
      end
      acc = (i < 10) && (i % 2 == 0);
      if (i < 10) check("stream_in_ready", 32'(in_ready), 32'(acc));
      tick();
      hist = {hist[1:0], acc};
      if (acc) begin
        last = 1 + n_acc;
        q.push_back(last);
        n_acc++;
      end
      check("stream_share_valid", 32'(share_valid), 32'(hist[0]));
      check("stream_res_valid", 32'(res_valid), 32'(hist[2]));
      check_shares("stream_shares", last);
      if (hist[2]) begin
        if (q.size() > 0) begin
          k = q.pop_front();
          check("stream_gadget", 32'(g_out0 ^ g_out1), 32'(tbl[k].prod));
        end else begin
          check("stream_queue_empty", 32'd0, 32'd1);
        end
      end
    end
    in_valid = 1'b0;
    check("stream_reseed_count", 32'(reseed_count), 32'd1);

    // Zero seed, simultaneous seed_valid/in_valid, seed_valid ignored in RUN
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("zs_wait_seed", 32'(reseed_req), 32'd1);
    seed = 32'h0;
    seed_valid = 1'b1;
    in_valid = 1'b1;
    in_a = 4'h5;
    in_b = 4'h3;
    check("zs_in_ready_wait", 32'(in_ready), 32'd0);
    tick();
    seed_valid = 1'b0;
    in_valid = 1'b0;
    check("zs_not_accepted", 32'(share_valid), 32'd0);
    check("zs_reseed_count", 32'(reseed_count), 32'd1);
    check("zs_in_ready", 32'(in_ready), 32'd1);
    seed = 32'h0000_ACE1;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    check("run_seed_ignored_count", 32'(reseed_count), 32'd1);
    check("run_seed_ignored_req", 32'(reseed_req), 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("zs_share_valid", 32'(share_valid), 32'd1);
    check("zs_shares", 32'({a_share0, a_share1, b_share0, b_share1, rand0, rand1}), 32'h41_30_00);

    // Reset in C1 drops the in-flight transaction
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_shares", 32'({a_share0, a_share1, b_share0, b_share1, rand0, rand1}), 32'd0);
    check("mid_rst_flags", 32'({share_valid, res_valid, in_ready, reseed_req}), 32'b0001);
    check("mid_rst_count", 32'(reseed_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_no_res", 32'({share_valid, res_valid}), 32'd0);
    end

    // RESEED_INTERVAL = 3 instance
    seed = 32'h0000_ACE1;
    seed_valid3 = 1'b1;
    tick();
    seed_valid3 = 1'b0;
    check("ri3_reseed_count", 32'(reseed_count3), 32'd1);
    check("ri3_in_ready", 32'(in_ready3), 32'd1);
    hist = '0;
    in_a = 4'hF;
    in_b = 4'hF;
    for (int i = 0; i < 10; i++) begin
      in_valid3 = 1'b1;
      acc = (i <= 4) && (i % 2 == 0);
      check("ri3_in_ready_seq", 32'(in_ready3), 32'(acc));
      tick();
      hist = {hist[1:0], acc};
      check("ri3_share_valid", 32'(share_valid3), 32'(hist[0]));
      check("ri3_res_valid", 32'(res_valid3), 32'(hist[2]));
      check("ri3_reseed_req", 32'(reseed_req3), 32'(i >= 4));
    end
    seed_valid3 = 1'b1;
    check("ri3_wait_in_ready", 32'(in_ready3), 32'd0);
    tick();
    seed_valid3 = 1'b0;
    in_valid3 = 1'b0;
    check("ri3_reseed_no_accept", 32'(share_valid3), 32'd0);
    check("ri3_reseed_count2", 32'(reseed_count3), 32'd2);
    check("ri3_run_again", 32'({reseed_req3, in_ready3}), 32'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/masked_share_feeder.md
Name: masked_share_feeder

Overview:
- Upstream neighbour of the two-stage masked AND gadget.
- Takes unmasked operand pairs over a valid/ready handshake and splits each operand into two Boolean shares using fresh LFSR randomness.
- Drives the gadget's a/b share ports and its rand0/rand1 ports, holding the rand words for the full 2-cycle gadget window.
- Asserts a result strobe aligned with the gadget's registered outputs, and forces a PRNG reseed after a fixed transaction count.

Parameters:
- WIDTH, 4, operand and share width; must satisfy 4*WIDTH <= LFSR_W.
- LFSR_W, 32, PRNG state width.
- RESEED_INTERVAL, 256, accepted transactions between mandatory reseeds; legal range 1..65535.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- seed  input  LFSR_W  reseed value.
- seed_valid  input  1  seed load strobe; honoured only in WAIT_SEED.
- reseed_req  output  1  high while the block is waiting for a seed.
- in_a  input  WIDTH  unmasked operand A.
- in_b  input  WIDTH  unmasked operand B.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept a pair this cycle.
- a_share0, a_share1, b_share0, b_share1  output  WIDTH each  registered shares to the gadget.
- rand0, rand1  output  WIDTH each  registered gadget randomness.
- share_valid  output  1  shares belong to a new transaction this cycle.
- res_valid  output  1  the gadget's out_share0/1 are valid this cycle.
- reseed_count  output  16  number of completed reseeds; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=0 at a clk edge):
  - all share and rand outputs, share_valid, res_valid, reseed_count, the transaction counter and the valid pipeline are cleared to 0;
  - the LFSR is set to 1;
  - state becomes WAIT_SEED.
  - Reset mid-transaction drops any in-flight transaction; no res_valid is produced for it.
- States:
  - WAIT_SEED: reseed_req=1, in_ready=0. When seed_valid=1, load the LFSR with seed, or with 1 if seed==0. Increment reseed_count, clear the transaction counter, and go to RUN.
  - RUN: reseed_req=0. in_ready=1 unless HOLD is set.
- HOLD: 1-bit flag, set on accept and cleared the next cycle. It throttles acceptance to at most one pair every 2 cycles.
- Accept: in_valid && in_ready at edge E0. At that edge:
  - mask_a = lfsr[WIDTH-1:0]
  - mask_b = lfsr[2W-1:W]
  - rand0 <= lfsr[3W-1:2W]
  - rand1 <= lfsr[4W-1:3W]
  - a_share0 <= in_a ^ mask_a; a_share1 <= mask_a
  - b_share0 <= in_b ^ mask_b; b_share1 <= mask_b
  - share_valid <= 1
  - the LFSR advances one step and the transaction counter increments.
- LFSR: Fibonacci, taps 32,22,2,1, shifting left. The new bit 0 is the XOR of the tapped bits. It advances only on accept, so there is one fresh word set per transaction.
- Timing:
  - shares are visible in cycle C1, after E0;
  - share_valid is high only in C1;
  - the share and rand outputs hold their values through C2;
  - rand0/rand1 change only on an accept, so they are stable across both gadget edges (E1 and E2). This is required for r0^r1 to cancel in the gadget's second stage.
- res_valid = share_valid delayed by 2 cycles, i.e. high in C3.
- Reseed trigger:
  - the transaction counter reaching RESEED_INTERVAL on an accept moves the state to WAIT_SEED at the same edge;
  - in-flight res_valid still completes;
  - seed_valid in RUN is ignored.
- Idle cycles: no in_valid means outputs hold their values and share_valid=0.
- Simultaneous seed_valid and in_valid in WAIT_SEED: seed is loaded, the input is not accepted (in_ready=0).
- Width rule: all XORs are bitwise at WIDTH. There is no carry anywhere.

Decomposition:
- Package masked_feeder_pkg:
  - state enum {WAIT_SEED, RUN};
  - LFSR_W default;
  - tap mask constant 32'h80200003;
  - zero-seed substitute constant 1.
- Sub-module share_lfsr holds the LFSR: load, step, and zero-seed guard.
- The top level holds the FSM, the HOLD flag, the counter, the share registers and the 2-deep valid shift.

Test Plan:
- Reset, then seed=32'hACE1 with seed_valid -> reseed_req drops after 1 cycle; reseed_count=1; in_ready=1.
- in_a=4'hB, in_b=4'h6 accepted -> in C1: a_share0^a_share1=4'hB, b_share0^b_share1=4'h6, share_valid=1. Then res_valid=1 in C3, and gadget out0^out1=4'h2.
- in_valid held high for 10 cycles -> exactly 5 accepts, with in_ready alternating 1/0. rand0/rand1 are constant across each 2-cycle window, and every res_valid recombines to in_a&in_b.
- seed=0 -> LFSR loads 1, and the first share masks equal the slices of 32'h00000001 (mask_a=4'h1, others 0).
- RESEED_INTERVAL=3 -> after the 3rd accept, reseed_req=1 and in_ready=0. The 3rd res_valid still fires; in_valid is ignored until seed_valid.
- rst=0 on the cycle after an accept -> no res_valid 2 cycles later; all outputs read 0; state is WAIT_SEED.
